// File: rtl/tiny16_pkg.sv
// Shared constants for the tiny16 memory subsystem: bus widths and requester ids.
// Used by the arbiter, its interface and the round-robin picker.
// No logic lives here.
package tiny16_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // Requester ids, also the encoding of the round-robin pointer.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester handshakes and the memory read/write ports.
// slave = arbiter side, master = requesters plus the memory model.
// Pure wiring, no latency of its own.
interface mem_arbiter_if;
  import tiny16_pkg::*;

  logic              req0, we0, gnt0, rvalid0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;

  logic              req1, we1, gnt1, rvalid1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;

  logic              mem_in_en, mem_out_en;
  logic [ADDR_W-1:0] mem_in_addr, mem_out_addr;
  logic [DATA_W-1:0] mem_in_data, mem_out_data;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_out_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_in_en, mem_in_addr, mem_in_data, mem_out_en, mem_out_addr
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_out_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_in_en, mem_in_addr, mem_in_data, mem_out_en, mem_out_addr
  );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: one-hot grant, the port other than last wins a tie.
// Purely combinational, zero latency.
// No backpressure; an ungranted requester simply retries next cycle.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // Single requester wins outright; on contention favour the port not served last.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 16-bit memory between fetch (port 0) and load/store (port 1), round-robin.
// Grant is combinational; read data returns one cycle after the grant with a valid pulse.
// Losing requester holds its request and retries; nothing is queued here.
module mem_arbiter
  import tiny16_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              last_gnt_q, last_gnt_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;

  rr_pick2 u_pick (
    .req_i  ({bus.req1, bus.req0}),
    .last_i (last_gnt_q),
    .gnt_o  (pick)
  );

  // Grant gating and steering of the winning request onto the memory ports.
  always_comb begin
    gnt       = rst ? 2'b00 : pick;
    any_gnt   = |gnt;
    sel       = gnt[1] ? PORT_LSU : PORT_FETCH;
    sel_we    = (sel == PORT_LSU) ? bus.we1    : bus.we0;
    sel_addr  = (sel == PORT_LSU) ? bus.addr1  : bus.addr0;
    sel_wdata = (sel == PORT_LSU) ? bus.wdata1 : bus.wdata0;
  end

  assign bus.gnt0         = gnt[0];
  assign bus.gnt1         = gnt[1];
  assign bus.mem_in_en    = any_gnt & sel_we;
  assign bus.mem_out_en   = any_gnt & ~sel_we;
  assign bus.mem_in_addr  = bus.mem_in_en  ? sel_addr  : '0;
  assign bus.mem_in_data  = bus.mem_in_en  ? sel_wdata : '0;
  assign bus.mem_out_addr = bus.mem_out_en ? sel_addr  : '0;

  // Read data passes straight through while valid, otherwise the last captured value.
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rvalid0_q ? bus.mem_out_data : hold0_q;
  assign bus.rdata1  = rvalid1_q ? bus.mem_out_data : hold1_q;

  // Next state: pointer follows the granted port, read grants schedule a valid pulse.
  always_comb begin
    last_gnt_d = any_gnt ? sel : last_gnt_q;
    rvalid0_d  = gnt[0] & ~bus.we0;
    rvalid1_d  = gnt[1] & ~bus.we1;
    hold0_d    = rvalid0_q ? bus.mem_out_data : hold0_q;
    hold1_d    = rvalid1_q ? bus.mem_out_data : hold1_q;
  end

  // State registers; after reset port 0 gets the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= PORT_LSU;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      hold0_q    <= '0;
      hold1_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small memory model.
// Stimulus pushes expected read data into per-port queues; a monitor pops on rvalid.
// Grants and memory enables are checked inline by the stimulus process.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic done = 1'b0;
  int   tests = 0;
  int   failed = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] mem [0:255];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, write on the falling edge of the grant cycle.
  always @(posedge clk) if (bus.mem_out_en) bus.mem_out_data <= mem[bus.mem_out_addr[7:0]];
  always @(negedge clk) if (bus.mem_in_en)  mem[bus.mem_in_addr[7:0]] <= bus.mem_in_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic g0, input logic g1,
                         input logic ie, input logic oe);
    chk({tag, "_gnt0"}, bus.gnt0, g0);
    chk({tag, "_gnt1"}, bus.gnt1, g1);
    chk({tag, "_in_en"}, bus.mem_in_en, ie);
    chk({tag, "_out_en"}, bus.mem_out_en, oe);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid pulse must match the oldest expected read for that port.
  always @(negedge clk) begin
    if (!done) begin
      if (bus.rvalid0) begin
        if (q0.size() == 0) begin
          tests++; failed++;
          $display("FAIL rvalid0_unexpected: got rdata0 0x%0h expected no pulse", bus.rdata0);
        end else chk("rdata0_on_valid", bus.rdata0, q0.pop_front());
      end
      if (bus.rvalid1) begin
        if (q1.size() == 0) begin
          tests++; failed++;
          $display("FAIL rvalid1_unexpected: got rdata1 0x%0h expected no pulse", bus.rdata1);
        end else chk("rdata1_on_valid", bus.rdata1, q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    mem[8'h11] = 16'hC0DE;
    mem[8'h12] = 16'h0F0F;
    bus.mem_out_data = 16'h0000;

    // Reset with both ports requesting reads: nothing may be granted.
    rst = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0012; bus.wdata0 = 16'h0000;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0011; bus.wdata1 = 16'h0000;
    @(negedge clk);
    chk_bus("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Contention straight out of reset: grants alternate starting with port 0.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk_bus("contend", (i % 2) == 0, (i % 2) == 1, 1'b0, 1'b1);
      chk("contend_rvalid0", bus.rvalid0, (i > 0) && ((i - 1) % 2 == 0));
      chk("contend_rvalid1", bus.rvalid1, (i > 0) && ((i - 1) % 2 == 1));
      if (i == 0) begin
        chk("post_reset_rdata0", bus.rdata0, 16'h0000);
        chk("post_reset_rdata1", bus.rdata1, 16'h0000);
      end
      if (i % 2 == 0) q0.push_back(16'h0F0F);
      else            q1.push_back(16'hC0DE);
    end
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    chk_bus("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_out_addr", bus.mem_out_addr, 16'h0000);
    chk("idle_in_addr", bus.mem_in_addr, 16'h0000);

    // Single read of 0x0010.
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    @(negedge clk);
    chk_bus("rd", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rd_out_addr", bus.mem_out_addr, 16'h0010);
    q0.push_back(16'hBEEF);
    step();
    bus.req0 = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rd_hold_rvalid0", bus.rvalid0, 1'b0);
    chk("rd_hold_rdata0", bus.rdata0, 16'hBEEF);

    // Port 1 write then read-after-write of the same address.
    step();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0020; bus.wdata1 = 16'h1234;
    @(negedge clk);
    chk_bus("raw_wr", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("raw_wr_addr", bus.mem_in_addr, 16'h0020);
    chk("raw_wr_data", bus.mem_in_data, 16'h1234);
    step();
    bus.we1 = 1'b0;
    @(negedge clk);
    chk_bus("raw_rd", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("raw_rd_addr", bus.mem_out_addr, 16'h0020);
    q1.push_back(16'h1234);
    step();
    bus.req1 = 1'b0;
    @(negedge clk);

    // Simultaneous writes serialize, then both are read back.
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0001; bus.wdata0 = 16'hAAAA;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0002; bus.wdata1 = 16'h5555;
    @(negedge clk);
    chk_bus("dw0", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("dw0_addr", bus.mem_in_addr, 16'h0001);
    chk("dw0_data", bus.mem_in_data, 16'hAAAA);
    step();
    bus.req0 = 1'b0;
    @(negedge clk);
    chk_bus("dw1", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("dw1_addr", bus.mem_in_addr, 16'h0002);
    chk("dw1_data", bus.mem_in_data, 16'h5555);
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.we1 = 1'b0;
    @(negedge clk);
    chk_bus("dr0", 1'b1, 1'b0, 1'b0, 1'b1);
    q0.push_back(16'hAAAA);
    step();
    bus.req0 = 1'b0;
    @(negedge clk);
    chk_bus("dr1", 1'b0, 1'b1, 1'b0, 1'b1);
    q1.push_back(16'h5555);
    step();
    bus.req1 = 1'b0;
    @(negedge clk);
    chk_bus("dr_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset arriving the cycle after a read grant.
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    @(negedge clk);
    chk_bus("mid_rd", 1'b1, 1'b0, 1'b0, 1'b1);
    q0.push_back(16'hBEEF);
    step();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0011;
    @(negedge clk);
    chk_bus("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_rvalid0", bus.rvalid0, 1'b1);
    step();
    rst = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("after_rst_rvalid0", bus.rvalid0, 1'b0);
    chk("after_rst_rdata0", bus.rdata0, 16'h0000);

    step();
    step();
    done = 1'b1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
